// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/next-PC controller with return-address stack and fetch handshake
//
// Sequences BOOT -> FETCH -> EXEC -> (FETCH | HALT) and applies the control
// unit's decoded outcome once per instruction.
// Optional build macro: PC_SEQ_PERF_EN enables the retired-instruction counter;
// without it instr_count is tied to zero.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   imem_req    fetch request (registered, high in FETCH)
//   imem_addr   fetch address, equals pc
//   imem_ack    instruction valid; sampled only in FETCH
//   ctrl_valid  decoded outcome present; sampled only in EXEC
//   br_taken    branch to br_target
//   is_call     push pc+1, jump to br_target
//   is_ret      pop return address into pc
//   is_halt     halt instruction
//   br_target   branch/call target
//   resume      leave HALT when no error flag is set
//   pc          program counter
//   exec_en     high in EXEC
//   halted      high in HALT
//   err_ovf     sticky call-with-full-stack flag
//   err_unf     sticky return-with-empty-stack flag
//   instr_count retired-instruction count (saturating)
module pc_sequencer #(
    parameter int AW          = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic          ctrl_valid,
    input  logic          br_taken,
    input  logic          is_call,
    input  logic          is_ret,
    input  logic          is_halt,
    input  logic [AW-1:0] br_target,
    input  logic          resume,
    output logic [AW-1:0] pc,
    output logic          exec_en,
    output logic          halted,
    output logic          err_ovf,
    output logic          err_unf,
    output logic [15:0]   instr_count
);
    localparam int SW = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {BOOT, FETCH, EXEC, HALT} state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [SW:0]   r_sp;
    logic [AW-1:0] r_stack [STACK_DEPTH];
    logic          r_imem_req;
    logic          r_err_ovf;
    logic          r_err_unf;

    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_top;
    logic          w_empty;
    logic          w_full;
    logic          w_err;
    logic          w_to_halt;

    assign w_pc_inc  = r_pc + AW'(1);
    assign w_top     = r_stack[r_sp[SW-1:0] - SW'(1)];
    assign w_empty   = (r_sp == '0);
    assign w_full    = (r_sp == (SW+1)'(STACK_DEPTH));
    // halt outranks everything, so a halt never raises a stack error
    assign w_err     = !is_halt && (is_ret ? w_empty : (is_call && w_full));
    assign w_to_halt = is_halt || w_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= BOOT;
            r_pc       <= '0;
            r_sp       <= '0;
            r_imem_req <= 1'b0;
            r_err_ovf  <= 1'b0;
            r_err_unf  <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
        end else begin
            case (r_state)
                BOOT: begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
                FETCH: if (imem_ack) begin
                    r_state    <= EXEC;
                    r_imem_req <= 1'b0;
                end
                EXEC: if (ctrl_valid) begin
                    r_state    <= w_to_halt ? HALT : FETCH;
                    r_imem_req <= !w_to_halt;
                    if (!is_halt) begin
                        if (is_ret) begin
                            if (w_empty) r_err_unf <= 1'b1;
                            else begin
                                r_sp <= r_sp - (SW+1)'(1);
                                r_pc <= w_top;
                            end
                        end else if (is_call) begin
                            if (w_full) r_err_ovf <= 1'b1;
                            else begin
                                r_stack[r_sp[SW-1:0]] <= w_pc_inc;
                                r_sp <= r_sp + (SW+1)'(1);
                                r_pc <= br_target;
                            end
                        end else r_pc <= br_taken ? br_target : w_pc_inc;
                    end
                end
                HALT: if (resume && !r_err_ovf && !r_err_unf) begin
                    r_state    <= FETCH;
                    r_imem_req <= 1'b1;
                end
                default: r_state <= BOOT;
            endcase
        end
    end

`ifdef PC_SEQ_PERF_EN
    logic [15:0] r_instr_count;
    logic        w_retire;

    // a halt instruction retires; an error-induced halt does not
    assign w_retire = (r_state == EXEC) && ctrl_valid && !w_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_instr_count <= '0;
        else if (w_retire && r_instr_count != 16'hFFFF) r_instr_count <= r_instr_count + 16'd1;
    end

    assign instr_count = r_instr_count;
`else
    assign instr_count = '0;
`endif

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign exec_en   = (r_state == EXEC);
    assign halted    = (r_state == HALT);
    assign err_ovf   = r_err_ovf;
    assign err_unf   = r_err_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: model-checked directed and random stimulus for pc_sequencer
module tb_pc_sequencer;
    localparam int P_BOOT = 0, P_FETCH = 1, P_EXEC = 2, P_HALT = 3;
    localparam int K_SEQ = 0, K_BR = 1, K_CALL = 2, K_RET = 3, K_HALT = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       imem_req, imem_ack = 1'b0;
    logic [7:0] imem_addr, pc, br_target = 8'h00;
    logic       ctrl_valid = 1'b0, br_taken = 1'b0, is_call = 1'b0, is_ret = 1'b0, is_halt = 1'b0;
    logic       resume = 1'b0;
    logic       exec_en, halted, err_ovf, err_unf;
    logic [15:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .ctrl_valid(ctrl_valid), .br_taken(br_taken),
        .is_call(is_call), .is_ret(is_ret), .is_halt(is_halt), .br_target(br_target),
        .resume(resume), .pc(pc), .exec_en(exec_en), .halted(halted),
        .err_ovf(err_ovf), .err_unf(err_unf), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    int m_phase = P_BOOT;
    int m_pc = 0;
    int m_sp = 0;
    int m_stk [DEPTH];
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    function automatic int bump(input int c);
        return (c < 65535) ? c + 1 : c;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= P_BOOT;
            m_pc    <= 0;
            m_sp    <= 0;
            m_cnt   <= 0;
            m_ovf   <= 1'b0;
            m_unf   <= 1'b0;
        end else if (m_phase == P_BOOT) m_phase <= P_FETCH;
        else if (m_phase == P_FETCH) begin
            if (imem_ack) m_phase <= P_EXEC;
        end else if (m_phase == P_HALT) begin
            if (resume && !m_ovf && !m_unf) m_phase <= P_FETCH;
        end else if (ctrl_valid) begin
            if (is_halt) begin
                m_phase <= P_HALT;
                m_cnt   <= bump(m_cnt);
            end else if (is_ret && m_sp == 0) begin
                m_unf   <= 1'b1;
                m_phase <= P_HALT;
            end else if (is_ret) begin
                m_pc    <= m_stk[m_sp-1];
                m_sp    <= m_sp - 1;
                m_cnt   <= bump(m_cnt);
                m_phase <= P_FETCH;
            end else if (is_call && m_sp == DEPTH) begin
                m_ovf   <= 1'b1;
                m_phase <= P_HALT;
            end else if (is_call) begin
                m_stk[m_sp] <= (m_pc + 1) % 256;
                m_sp    <= m_sp + 1;
                m_pc    <= int'(br_target);
                m_cnt   <= bump(m_cnt);
                m_phase <= P_FETCH;
            end else begin
                m_pc    <= br_taken ? int'(br_target) : (m_pc + 1) % 256;
                m_cnt   <= bump(m_cnt);
                m_phase <= P_FETCH;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [36:0] dut_vec, exp_vec;
    logic [15:0] exp_cnt;
    always_comb begin
`ifdef PC_SEQ_PERF_EN
        exp_cnt = 16'(m_cnt);
`else
        exp_cnt = 16'h0000;
`endif
        dut_vec = {imem_req, imem_addr, pc, exec_en, halted, err_ovf, err_unf, instr_count};
        exp_vec = {m_phase == P_FETCH, 8'(m_pc), 8'(m_pc), m_phase == P_EXEC, m_phase == P_HALT,
                   m_ovf, m_unf, exp_cnt};
    end

    always @(negedge clk) chk("outputs_vs_model", 64'(dut_vec), 64'(exp_vec));

    task automatic wait_phase(input int p);
        int n = 0;
        while (m_phase != p && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (m_phase != p) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_phase: got phase %0d expected %0d", m_phase, p);
        end
    endtask

    task automatic fetch(input int delay, output logic [7:0] addr, output int held, output int t);
        wait_phase(P_FETCH);
        addr = imem_addr;
        held = 0;
        t = cyc;
        for (int k = 0; k <= delay; k++) begin
            if (imem_req && !exec_en && imem_addr == addr) held++;
            imem_ack = (k == delay);
            @(negedge clk);
        end
        imem_ack = 1'b0;
    endtask

    task automatic exec(input int kind, input logic [7:0] tgt);
        wait_phase(P_EXEC);
        ctrl_valid = 1'b1;
        is_halt    = (kind == K_HALT);
        is_ret     = (kind == K_RET);
        is_call    = (kind == K_CALL);
        br_taken   = (kind == K_BR);
        br_target  = tgt;
        @(negedge clk);
        {ctrl_valid, is_halt, is_ret, is_call, br_taken} = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    logic [7:0] a;
    int held, t0, t1;

    initial begin
        #2 reset = 1'b0;
        #1 chk("reset_state", 64'(dut_vec), 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;

        fetch(0, a, held, t0);
        chk("seq_addr0", 64'(a), 64'h00);
        for (int i = 1; i <= 3; i++) begin
            exec(K_SEQ, 8'h00);
            fetch(0, a, held, t1);
            chk("seq_addr", 64'(a), 64'(i));
            chk("fetch_exec_cycles", 64'(t1 - t0), 64'd2);
            t0 = t1;
        end
        exec(K_BR, 8'h10);

        fetch(3, a, held, t0);
        chk("slow_fetch_addr", 64'(a), 64'h10);
        chk("slow_fetch_req_cycles", 64'(held), 64'd4);

        exec(K_CALL, 8'h40);
        fetch(0, a, held, t0);
        chk("call_target", 64'(a), 64'h40);
        exec(K_SEQ, 8'h00);
        fetch(0, a, held, t0);
        chk("after_call_seq", 64'(a), 64'h41);
        exec(K_RET, 8'h00);
        fetch(0, a, held, t0);
        chk("ret_addr", 64'(a), 64'h11);
        chk("model_sp_after_ret", 64'(m_sp), 64'd0);

        for (int i = 0; i < 4; i++) begin
            exec(K_CALL, 8'(8'h20 + i));
            fetch(0, a, held, t0);
        end
        chk("nested_call_addr", 64'(a), 64'h23);
        exec(K_CALL, 8'h30);
        chk("ovf_flag", 64'(err_ovf), 64'd1);
        chk("ovf_halted", 64'(halted), 64'd1);
        chk("ovf_pc", 64'(pc), 64'h23);
        resume = 1'b1;
        repeat (3) @(negedge clk);
        resume = 1'b0;
        chk("ovf_resume_ignored", 64'(halted), 64'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 chk("reset_after_ovf", 64'(dut_vec), 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;

        fetch(0, a, held, t0);
        exec(K_RET, 8'h00);
        chk("unf_flag", 64'({err_unf, halted, err_ovf}), 64'b110);
        do_reset();

        fetch(0, a, held, t0);
        exec(K_BR, 8'h05);
        fetch(0, a, held, t0);
        exec(K_HALT, 8'h00);
        chk("halt_state", 64'({halted, err_ovf, err_unf, pc}), {53'd0, 3'b100, 8'h05});
        resume = 1'b1;
        @(negedge clk);
        resume = 1'b0;
        fetch(0, a, held, t0);
        chk("refetch_after_resume", 64'(a), 64'h05);
        exec(K_BR, 8'hFF);
        fetch(0, a, held, t0);
        exec(K_SEQ, 8'h00);
        fetch(0, a, held, t0);
        chk("pc_wrap", 64'(a), 64'h00);

        do_reset();
        for (int i = 0; i < 10; i++) begin
            fetch(0, a, held, t0);
            exec(K_SEQ, 8'h00);
        end
`ifdef PC_SEQ_PERF_EN
        chk("instr_count_10", 64'(instr_count), 64'd10);
`else
        chk("instr_count_off", 64'(instr_count), 64'd0);
`endif
        fetch(0, a, held, t0);
        #2 reset = 1'b0;
        #1 chk("async_reset_mid_exec", 64'({pc, instr_count, exec_en}), 64'd0);
        @(negedge clk);
        #2 reset = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ((m_phase == P_HALT && (m_ovf || m_unf) && $urandom_range(0, 3) == 0) ||
                $urandom_range(0, 599) == 0) begin
                {imem_ack, ctrl_valid, is_halt, is_ret, is_call, br_taken, resume} = '0;
                #2 reset = 1'b0;
                @(negedge clk);
                #2 reset = 1'b1;
            end else begin
                imem_ack   = 1'($urandom_range(0, 1));
                ctrl_valid = 1'($urandom_range(0, 1));
                is_halt    = ($urandom_range(0, 19) == 0);
                is_ret     = ($urandom_range(0, 3) == 0);
                is_call    = ($urandom_range(0, 3) == 0);
                br_taken   = 1'($urandom_range(0, 1));
                resume     = ($urandom_range(0, 3) == 0);
                br_target  = 8'($urandom);
            end
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
